// File: rtl/led_shift_driver.sv
// rtl/led_shift_driver.sv - serial back end driving a 74HC595-style LED chain
module led_shift_driver #(
    parameter int WIDTH      = 72,
    parameter int CLK_DIV    = 4,
    parameter int DWELL      = 4096,
    parameter int CLR_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] display_bits,
    output logic             sclk,
    output logic             sdata,
    output logic             sload,
    output logic             sclr_n,
    output logic             digit_done,
    output logic             busy
);

    // Two clocks let the sequencer update its state and its row register
    // after digit_done before the word is sampled.
    localparam int SETTLE_CYCLES = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared dwell/divider counter covers every timed state.
    localparam int CNT_MAX = max2(max2(CLR_CYCLES, DWELL), max2(CLK_DIV, SETTLE_CYCLES));
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] CLR_LAST    = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL - 1);
    localparam logic [BW-1:0] BITS_FULL   = BW'(WIDTH);
    localparam logic [BW-1:0] BITS_ONE    = BW'(1);

    typedef enum logic [2:0] {
        CLEAR    = 3'd0,
        SETTLE   = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LOAD     = 3'd4,
        DWELL_ST = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [WIDTH-1:0] shadow, shadow_nxt;

    // Next-state, counter and shadow-word logic; every timed state leaves on its last clk.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CW'(1);
        bit_cnt_nxt = bit_cnt;
        shadow_nxt  = shadow;
        case (state)
            CLEAR: begin
                if (cnt == CLR_LAST) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt   = SHIFT_LO;
                    cnt_nxt     = '0;
                    shadow_nxt  = display_bits;
                    bit_cnt_nxt = BITS_FULL;
                end
            end
            SHIFT_LO: begin
                if (cnt == DIV_LAST) begin
                    state_nxt = SHIFT_HI;
                    cnt_nxt   = '0;
                end
            end
            SHIFT_HI: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt     = '0;
                    shadow_nxt  = shadow << 1;
                    bit_cnt_nxt = bit_cnt - BW'(1);
                    state_nxt   = (bit_cnt == BITS_ONE) ? LOAD : SHIFT_LO;
                end
            end
            LOAD: begin
                if (cnt == DIV_LAST) begin
                    state_nxt = DWELL_ST;
                    cnt_nxt   = '0;
                end
            end
            DWELL_ST: begin
                if (cnt == DWELL_LAST) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counters and shadow word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            cnt     <= '0;
            bit_cnt <= '0;
            shadow  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shadow  <= shadow_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk       <= 1'b0;
            sdata      <= 1'b0;
            sload      <= 1'b0;
            sclr_n     <= 1'b0;
            digit_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sclk       <= (state_nxt == SHIFT_HI);
            sdata      <= ((state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI)) ?
                          shadow_nxt[WIDTH-1] : 1'b0;
            sload      <= (state_nxt == LOAD);
            sclr_n     <= (state_nxt != CLEAR);
            digit_done <= (state_nxt == DWELL_ST) && (cnt_nxt == DWELL_LAST);
            busy       <= (state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI) ||
                          (state_nxt == LOAD);
        end
    end

endmodule
